writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Parametrised successor of the single-register WB stage. It sits between MEM and the GPR/CSR files.
- Buffers up to DEPTH MEM uops in an in-order queue with a valid/ready handshake.
- Binds out-of-band, in-order load responses to the uops that issued them, and aligns and extends the load data.
- Commits one uop per cycle to GPR/CSR under register-file backpressure, and keeps a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, datapath width (32 or 64)
- RF_ADDR_WIDTH, 5, GPR index width
- CSR_ADDR_WIDTH, 12, CSR address width
- DEPTH, 2, queue entries; power of two, at least 2
- RET_CNT_WIDTH, 64, retire counter width

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- mem_valid_i  in  1  MEM uop valid
- mem_ready_o  out  1  WB accepts uop this cycle
- mem_rd_i  in  RF_ADDR_WIDTH  destination GPR
- mem_gpr_we_i  in  1  uop writes GPR
- mem_gpr_sel_i  in  2  GPR source: 00 exe_out, 01 load data, 10 op3, 11 reserved (treated as 00)
- mem_csr_we_i  in  1  uop writes CSR
- mem_csr_waddr_i  in  CSR_ADDR_WIDTH  CSR address
- mem_exe_out_i  in  DATA_WIDTH  ALU/CSR new value
- mem_op3_i  in  DATA_WIDTH  third operand (old CSR value)
- mem_ld_size_i  in  2  00 byte, 01 half, 10 word, 11 double
- mem_ld_unsigned_i  in  1  zero-extend load
- mem_ld_offset_i  in  log2(DATA_WIDTH/8)  byte offset in bus word
- d_m_rvalid_i  in  1  load response valid
- d_m_rdata_i  in  DATA_WIDTH  load response data
- rf_ready_i  in  1  GPR/CSR write ports free
- rd_o  out  RF_ADDR_WIDTH  committing rd
- gpr_wdata_o  out  DATA_WIDTH  GPR write data
- gpr_wdata_valid_o  out  1  GPR write strobe
- csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address
- csr_wdata_o  out  DATA_WIDTH  CSR write data (= exe_out)
- csr_wdata_valid_o  out  1  CSR write strobe
- instr_committed_o  out  1  head retired this cycle
- retire_cnt_o  out  RET_CNT_WIDTH  retired uop count
- rsp_err_o  out  1  sticky: load response with no pending load

Behaviour:
- Reset (async, rst_i=1):
  - Queue empty and all entry ld_pending flags cleared.
  - retire_cnt_o=0, rsp_err_o=0.
  - All strobes 0; rd_o=0; data outputs 0.
  - mem_ready_o=1 after reset deasserts.
  - Reset mid-operation discards all entries. Later responses to discarded loads set rsp_err_o.
- Queue:
  - Circular buffer with wr_ptr, rd_ptr, and count 0..DEPTH.
  - Enqueue when mem_valid_i & mem_ready_o.
  - mem_ready_o = (count<DEPTH) | commit, so a full queue accepts when the head commits the same cycle (count unchanged).
- Load tracking:
  - An entry with gpr_we=1 and sel=01 is enqueued with ld_pending=1.
  - d_m_rvalid_i binds to the oldest entry with ld_pending=1: stores d_m_rdata_i, clears ld_pending.
  - A response arriving in the same cycle as its uop's enqueue binds to that new entry.
  - A response with no pending entry is dropped and sets rsp_err_o; it stays set until reset.
- Commit:
  - commit = count>0 & rf_ready_i & !head.ld_pending.
  - Outputs are combinational from the head. Minimum latency is 1 cycle from enqueue to commit, since the entry is registered first.
  - gpr_wdata_valid_o = commit & gpr_we & (rd!=0).
  - csr_wdata_valid_o = commit & csr_we.
  - rd_o = head.rd when commit, else 0.
  - instr_committed_o = commit, including uops with no write.
  - retire_cnt_o increments on commit and wraps modulo 2^RET_CNT_WIDTH.
- Load alignment:
  - Shift = rdata >> (offset*8); then take 8/16/32/64 bits and sign- or zero-extend to DATA_WIDTH.
  - Size 11 when DATA_WIDTH=32 is treated as word.
  - Misaligned offsets are not checked; the low bits are used as given.
- Stall: rf_ready_i=0 holds the head, and strobes stay 0.
- Empty queue: commit=0.

Test Plan:
- Reset, then three back-to-back ALU uops (rd=1,2,3; exe_out 0xA,0xB,0xC; rf_ready=1) -> gpr_wdata_valid_o high on cycles 1–3 with matching rd/data; retire_cnt_o=3.
- Byte load, offset 2, signed, rdata=0x0080_0000, response 3 cycles late -> head blocks 3 cycles, then gpr_wdata_o=0xFFFF_FF80; the same uop with unsigned -> 0x0000_0080.
- DEPTH=2: hold rf_ready_i=0, push 3 uops -> mem_ready_o=0 after 2. Raise rf_ready_i with the third uop still valid -> enqueue and commit in the same cycle, with count staying 2.
- CSR uop (csr_we=1, gpr_sel=10, rd=5, waddr=0x300, exe_out=0x8, op3=0x1800) -> csr_wdata_valid_o=1 with csr_wdata_o=0x8 and gpr_wdata_o=0x1800 in the same cycle. The same uop with rd=0 -> no GPR strobe.
- Two outstanding loads, responses 0x11 then 0x22 -> commits in order, with data 0x11 then 0x22. An extra response -> rsp_err_o=1.
- Assert rst_i with 2 entries queued, one load pending -> outputs 0 immediately and retire_cnt_o=0. A response after reset -> rsp_err_o=1, no commit.

Source files
------------

// File: rtl/writeback_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : writeback_queue                                                 |
// | Purpose  : In-order WB queue binding load responses and committing one     |
// |            uop per cycle to the GPR/CSR files.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module writeback_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int DEPTH          = 2,
  parameter int RET_CNT_WIDTH  = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               mem_valid_i,
  output logic                               mem_ready_o,
  input  logic [RF_ADDR_WIDTH-1:0]           mem_rd_i,
  input  logic                               mem_gpr_we_i,
  input  logic [1:0]                         mem_gpr_sel_i,
  input  logic                               mem_csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0]          mem_csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]              mem_exe_out_i,
  input  logic [DATA_WIDTH-1:0]              mem_op3_i,
  input  logic [1:0]                         mem_ld_size_i,
  input  logic                               mem_ld_unsigned_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]    mem_ld_offset_i,
  input  logic                               d_m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              d_m_rdata_i,
  input  logic                               rf_ready_i,
  output logic [RF_ADDR_WIDTH-1:0]           rd_o,
  output logic [DATA_WIDTH-1:0]              gpr_wdata_o,
  output logic                               gpr_wdata_valid_o,
  output logic [CSR_ADDR_WIDTH-1:0]          csr_waddr_o,
  output logic [DATA_WIDTH-1:0]              csr_wdata_o,
  output logic                               csr_wdata_valid_o,
  output logic                               instr_committed_o,
  output logic [RET_CNT_WIDTH-1:0]           retire_cnt_o,
  output logic                               rsp_err_o
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_OFF_W = $clog2(DATA_WIDTH/8);
  localparam int                 c_SH_W  = $clog2(DATA_WIDTH) + 1;
  localparam logic [c_PTR_W:0]   c_FULL  = DEPTH[c_PTR_W:0];

  // Entry payload
  logic [RF_ADDR_WIDTH-1:0]  r_rd        [DEPTH];
  logic [1:0]                r_gpr_sel   [DEPTH];
  logic [CSR_ADDR_WIDTH-1:0] r_csr_waddr [DEPTH];
  logic [DATA_WIDTH-1:0]     r_exe_out   [DEPTH];
  logic [DATA_WIDTH-1:0]     r_op3       [DEPTH];
  logic [1:0]                r_ld_size   [DEPTH];
  logic [c_OFF_W-1:0]        r_ld_offset [DEPTH];
  logic [DATA_WIDTH-1:0]     r_ld_data   [DEPTH];
  logic [DEPTH-1:0]          r_gpr_we;
  logic [DEPTH-1:0]          r_csr_we;
  logic [DEPTH-1:0]          r_ld_unsigned;

  // Control state
  logic [DEPTH-1:0]          r_pending;
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_PTR_W:0]          r_count;
  logic [RET_CNT_WIDTH-1:0]  r_retire_cnt;
  logic                      r_rsp_err;

  logic                      w_commit;
  logic                      w_enq;
  logic                      w_enq_load;
  logic                      w_bind_hit;
  logic [c_PTR_W-1:0]        w_bind_idx;
  logic                      w_bind_old;
  logic                      w_bind_new;
  logic                      w_rsp_err;

  logic [DATA_WIDTH-1:0]     w_shifted;
  logic [c_SH_W-1:0]         w_ext_sh;
  logic [DATA_WIDTH-1:0]     w_left;
  logic signed [DATA_WIDTH-1:0] w_left_s;
  logic [DATA_WIDTH-1:0]     w_zext;
  logic [DATA_WIDTH-1:0]     w_sext;
  logic [DATA_WIDTH-1:0]     w_ld_value;
  logic [DATA_WIDTH-1:0]     w_gpr_data;

  assign w_commit    = (r_count != '0) & rf_ready_i & ~r_pending[r_rd_ptr];
  assign mem_ready_o = (r_count != c_FULL) | w_commit;
  assign w_enq       = mem_valid_i & mem_ready_o;
  assign w_enq_load  = mem_gpr_we_i & (mem_gpr_sel_i == 2'b01);

  // Oldest pending load among occupied entries, walking from the head
  always_comb begin
    w_bind_hit = 1'b0;
    w_bind_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_bind_hit && (i < int'(r_count)) && r_pending[r_rd_ptr + c_PTR_W'(i)]) begin
        w_bind_hit = 1'b1;
        w_bind_idx = r_rd_ptr + c_PTR_W'(i);
      end
    end
  end

  // A response with nothing older pending may belong to the load entering now
  assign w_bind_old = d_m_rvalid_i & w_bind_hit;
  assign w_bind_new = d_m_rvalid_i & ~w_bind_hit & w_enq & w_enq_load;
  assign w_rsp_err  = d_m_rvalid_i & ~w_bind_hit & ~w_bind_new;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_retire_cnt <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wr_ptr            <= r_wr_ptr + 1'b1;
        r_pending[r_wr_ptr] <= w_enq_load & ~w_bind_new;
      end
      if (w_bind_old) begin
        r_pending[w_bind_idx] <= 1'b0;
      end
      if (w_commit) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_retire_cnt <= r_retire_cnt + 1'b1;
      end
      case ({w_enq, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_rsp_err) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only observed through occupied entries
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_rd[r_wr_ptr]          <= mem_rd_i;
      r_gpr_we[r_wr_ptr]      <= mem_gpr_we_i;
      r_gpr_sel[r_wr_ptr]     <= mem_gpr_sel_i;
      r_csr_we[r_wr_ptr]      <= mem_csr_we_i;
      r_csr_waddr[r_wr_ptr]   <= mem_csr_waddr_i;
      r_exe_out[r_wr_ptr]     <= mem_exe_out_i;
      r_op3[r_wr_ptr]         <= mem_op3_i;
      r_ld_size[r_wr_ptr]     <= mem_ld_size_i;
      r_ld_unsigned[r_wr_ptr] <= mem_ld_unsigned_i;
      r_ld_offset[r_wr_ptr]   <= mem_ld_offset_i;
    end
    if (w_bind_old) begin
      r_ld_data[w_bind_idx] <= d_m_rdata_i;
    end else if (w_bind_new) begin
      r_ld_data[r_wr_ptr] <= d_m_rdata_i;
    end
  end

  // Alignment: move the addressed bytes down, then push the loaded field to
  // the top so one right shift both truncates and extends it.
  assign w_shifted = r_ld_data[r_rd_ptr] >> {r_ld_offset[r_rd_ptr], 3'b000};

  always_comb begin
    w_ext_sh = '0;
    case (r_ld_size[r_rd_ptr])
      2'b00:   w_ext_sh = c_SH_W'(DATA_WIDTH - 8);
      2'b01:   w_ext_sh = c_SH_W'(DATA_WIDTH - 16);
      2'b10:   w_ext_sh = c_SH_W'(DATA_WIDTH - 32);
      default: w_ext_sh = '0;
    endcase
  end

  assign w_left     = w_shifted << w_ext_sh;
  assign w_left_s   = w_left;
  assign w_zext     = w_left >> w_ext_sh;
  assign w_sext     = w_left_s >>> w_ext_sh;
  assign w_ld_value = r_ld_unsigned[r_rd_ptr] ? w_zext : w_sext;

  always_comb begin
    w_gpr_data = r_exe_out[r_rd_ptr];
    case (r_gpr_sel[r_rd_ptr])
      2'b01:   w_gpr_data = w_ld_value;
      2'b10:   w_gpr_data = r_op3[r_rd_ptr];
      default: w_gpr_data = r_exe_out[r_rd_ptr];
    endcase
  end

  assign instr_committed_o = w_commit;
  assign rd_o              = w_commit ? r_rd[r_rd_ptr] : '0;
  assign gpr_wdata_valid_o = w_commit & r_gpr_we[r_rd_ptr] & (r_rd[r_rd_ptr] != '0);
  assign gpr_wdata_o       = w_commit ? w_gpr_data : '0;
  assign csr_wdata_valid_o = w_commit & r_csr_we[r_rd_ptr];
  assign csr_waddr_o       = w_commit ? r_csr_waddr[r_rd_ptr] : '0;
  assign csr_wdata_o       = w_commit ? r_exe_out[r_rd_ptr] : '0;
  assign retire_cnt_o      = r_retire_cnt;
  assign rsp_err_o         = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_writeback_queue                                              |
// | Purpose  : Directed and random stimulus against a queue-based model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_writeback_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        mem_gpr_we = 1'b0;
  logic [1:0]  mem_gpr_sel = '0;
  logic        mem_csr_we = 1'b0;
  logic [11:0] mem_csr_waddr = '0;
  logic [31:0] mem_exe_out = '0;
  logic [31:0] mem_op3 = '0;
  logic [1:0]  mem_ld_size = '0;
  logic        mem_ld_unsigned = 1'b0;
  logic [1:0]  mem_ld_offset = '0;
  logic        d_rvalid = 1'b0;
  logic [31:0] d_rdata = '0;
  logic        rf_ready = 1'b1;

  logic        mem_ready;
  logic [4:0]  rd;
  logic [31:0] gpr_wdata;
  logic        gpr_wdata_valid;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wdata_valid;
  logic        instr_committed;
  logic [63:0] retire_cnt;
  logic        rsp_err;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready),
    .mem_rd_i(mem_rd), .mem_gpr_we_i(mem_gpr_we), .mem_gpr_sel_i(mem_gpr_sel),
    .mem_csr_we_i(mem_csr_we), .mem_csr_waddr_i(mem_csr_waddr),
    .mem_exe_out_i(mem_exe_out), .mem_op3_i(mem_op3),
    .mem_ld_size_i(mem_ld_size), .mem_ld_unsigned_i(mem_ld_unsigned),
    .mem_ld_offset_i(mem_ld_offset),
    .d_m_rvalid_i(d_rvalid), .d_m_rdata_i(d_rdata), .rf_ready_i(rf_ready),
    .rd_o(rd), .gpr_wdata_o(gpr_wdata), .gpr_wdata_valid_o(gpr_wdata_valid),
    .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata), .csr_wdata_valid_o(csr_wdata_valid),
    .instr_committed_o(instr_committed), .retire_cnt_o(retire_cnt), .rsp_err_o(rsp_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        gpr_we;
    logic [1:0]  sel;
    logic        csr_we;
    logic [11:0] waddr;
    logic [31:0] exe;
    logic [31:0] op3;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic        pend;
    logic [31:0] data;
  } uop_t;

  uop_t        mq[$];
  logic [63:0] m_ret = '0;
  logic        m_err = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Field extraction by arithmetic: take the value modulo 2^n, fold into the negative range if signed
  function automatic logic [31:0] load_value(input logic [31:0] raw, input logic [1:0] size,
                                             input logic uns, input logic [1:0] off);
    logic [63:0] v;
    logic [63:0] span;
    int          nbits;
    v     = {32'h0, raw} >> (8 * off);
    nbits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    span  = 64'd1 << nbits;
    v     = v % span;
    if (!uns && (v >= span / 2)) v = v - span;
    return v[31:0];
  endfunction

  function automatic bit m_commit();
    if (mq.size() == 0) return 1'b0;
    return rf_ready && !mq[0].pend;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ret = '0;
    m_err = 1'b0;
  endtask

  task automatic compare_model();
    bit          c;
    uop_t        h;
    logic [31:0] gd;
    c = m_commit();
    chk("ready", mem_ready, (mq.size() < DEPTH) || c);
    chk("commit", instr_committed, c);
    if (c) begin
      h  = mq[0];
      gd = (h.sel == 2'b01) ? load_value(h.data, h.size, h.uns, h.off) :
           (h.sel == 2'b10) ? h.op3 : h.exe;
      chk("rd", rd, h.rd);
      chk("gpr_v", gpr_wdata_valid, h.gpr_we && (h.rd != 0));
      if (h.gpr_we && (h.rd != 0)) chk("gpr_d", gpr_wdata, gd);
      chk("csr_v", csr_wdata_valid, h.csr_we);
      if (h.csr_we) begin
        chk("csr_a", csr_waddr, h.waddr);
        chk("csr_d", csr_wdata, h.exe);
      end
    end else begin
      chk("rd_idle", rd, 0);
      chk("gpr_v_idle", gpr_wdata_valid, 0);
      chk("csr_v_idle", csr_wdata_valid, 0);
    end
    chk("retire", retire_cnt, m_ret);
    chk("err", rsp_err, m_err);
  endtask

  task automatic model_update();
    bit   c;
    bit   found;
    uop_t e;
    c = m_commit();
    if (c) begin
      void'(mq.pop_front());
      m_ret++;
    end
    if (mem_valid && ((mq.size() + (c ? 1 : 0)) < DEPTH || c)) begin
      e.rd = mem_rd;  e.gpr_we = mem_gpr_we; e.sel = mem_gpr_sel;
      e.csr_we = mem_csr_we; e.waddr = mem_csr_waddr;
      e.exe = mem_exe_out; e.op3 = mem_op3;
      e.size = mem_ld_size; e.uns = mem_ld_unsigned; e.off = mem_ld_offset;
      e.pend = mem_gpr_we && (mem_gpr_sel == 2'b01);
      e.data = '0;
      mq.push_back(e);
    end
    if (d_rvalid) begin
      found = 1'b0;
      foreach (mq[i]) begin
        if (!found && mq[i].pend) begin
          e = mq[i];
          e.pend = 1'b0;
          e.data = d_rdata;
          mq[i] = e;
          found = 1'b1;
        end
      end
      if (!found) m_err = 1'b1;
    end
  endtask

  // Phase: inputs change at posedge+1, outputs are compared at posedge+4
  task automatic peek();
    #3;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    peek();
    tick();
  endtask

  task automatic set_uop(input logic [4:0] r, input logic gwe, input logic [1:0] sel,
                         input logic cwe, input logic [11:0] wa, input logic [31:0] exe,
                         input logic [31:0] op3, input logic [1:0] size, input logic uns,
                         input logic [1:0] off);
    mem_valid = 1'b1; mem_rd = r; mem_gpr_we = gwe; mem_gpr_sel = sel;
    mem_csr_we = cwe; mem_csr_waddr = wa; mem_exe_out = exe; mem_op3 = op3;
    mem_ld_size = size; mem_ld_unsigned = uns; mem_ld_offset = off;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    peek();
    chk("rst_gpr_d", gpr_wdata, 0);
    chk("rst_csr_d", csr_wdata, 0);
    chk("rst_csr_a", csr_waddr, 0);
    tick();

    // Back-to-back ALU uops
    for (int k = 1; k <= 3; k++) begin
      set_uop(5'(k), 1'b1, 2'b00, 1'b0, '0, 32'h9 + 32'(k), '0, 2'b10, 1'b0, 2'b00);
      cycle();
    end
    mem_valid = 1'b0;
    cycle();
    peek();
    chk("alu_retire3", retire_cnt, 3);
    tick();

    // Byte load at offset 2, response three cycles late; signed then unsigned
    for (int u = 0; u < 2; u++) begin
      set_uop(5'd7, 1'b1, 2'b01, 1'b0, '0, '0, '0, 2'b00, 1'(u), 2'd2);
      cycle();
      mem_valid = 1'b0;
      repeat (2) cycle();
      d_rvalid = 1'b1;
      d_rdata  = 32'h0080_0000;
      cycle();
      d_rvalid = 1'b0;
      peek();
      chk(u ? "ld_zext" : "ld_sext", gpr_wdata, u ? 32'h0000_0080 : 32'hFFFF_FF80);
      tick();
    end

    // Full queue with commit-and-enqueue in the same cycle
    rf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_uop(5'(10 + k), 1'b1, 2'b00, 1'b0, '0, 32'h100 + 32'(k), '0, 2'b10, 1'b0, 2'b00);
      peek();
      if (k == 2) chk("full_not_ready", mem_ready, 0);
      tick();
    end
    rf_ready = 1'b1;
    peek();
    chk("full_pass_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    rf_ready  = 1'b0;
    peek();
    chk("still_full", mem_ready, 0);
    tick();
    rf_ready = 1'b1;
    repeat (3) cycle();

    // CSR uop returning the old value into the GPR, then the rd=0 variant
    for (int z = 0; z < 2; z++) begin
      set_uop(z ? 5'd0 : 5'd5, 1'b1, 2'b10, 1'b1, 12'h300, 32'h8, 32'h1800, 2'b10, 1'b0, 2'b00);
      cycle();
      mem_valid = 1'b0;
      peek();
      chk("csr_valid", csr_wdata_valid, 1);
      chk("csr_data", csr_wdata, 32'h8);
      chk("gpr_strobe", gpr_wdata_valid, z ? 0 : 1);
      if (z == 0) chk("csr_old", gpr_wdata, 32'h1800);
      tick();
    end

    // Two outstanding loads, in-order responses, then a stray response
    set_uop(5'd8, 1'b1, 2'b01, 1'b0, '0, '0, '0, 2'b10, 1'b0, 2'b00);
    cycle();
    set_uop(5'd9, 1'b1, 2'b01, 1'b0, '0, '0, '0, 2'b10, 1'b0, 2'b00);
    cycle();
    mem_valid = 1'b0;
    d_rvalid  = 1'b1;
    d_rdata   = 32'h11;
    cycle();
    d_rdata = 32'h22;
    peek();
    chk("ld_first", gpr_wdata, 32'h11);
    tick();
    d_rvalid = 1'b0;
    peek();
    chk("ld_second", gpr_wdata, 32'h22);
    tick();
    d_rvalid = 1'b1;
    d_rdata  = 32'h33;
    cycle();
    d_rvalid = 1'b0;
    peek();
    chk("stray_err", rsp_err, 1);
    tick();

    // Reset with two entries queued, one load pending
    pulse_reset();
    rf_ready = 1'b0;
    set_uop(5'd3, 1'b1, 2'b00, 1'b0, '0, 32'h33, '0, 2'b10, 1'b0, 2'b00);
    cycle();
    set_uop(5'd4, 1'b1, 2'b01, 1'b0, '0, '0, '0, 2'b10, 1'b0, 2'b00);
    cycle();
    mem_valid = 1'b0;
    rf_ready  = 1'b1;
    peek();
    chk("pre_rst_commit", instr_committed, 1);
    rst = 1'b1;
    #1;
    chk("rst_commit", instr_committed, 0);
    chk("rst_gpr_v", gpr_wdata_valid, 0);
    chk("rst_rd", rd, 0);
    chk("rst_retire", retire_cnt, 0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    d_rvalid = 1'b1;
    d_rdata  = 32'h44;
    cycle();
    d_rvalid = 1'b0;
    peek();
    chk("post_rst_err", rsp_err, 1);
    chk("post_rst_nocommit", instr_committed, 0);
    tick();

    // Randomized traffic; responses only issued when a load is outstanding
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      int npend;
      bit c;
      rf_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6)
        set_uop(5'($urandom_range(0, 31)), ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 12'($urandom), $urandom, $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else
        mem_valid = 1'b0;
      npend = 0;
      foreach (mq[i]) if (mq[i].pend) npend++;
      c = m_commit();
      if (mem_valid && (mq.size() < DEPTH || c) && mem_gpr_we && (mem_gpr_sel == 2'b01)) npend++;
      d_rvalid = (npend > 0) && ($urandom_range(0, 9) < 4);
      d_rdata  = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
